// File: rtl/gb_line_scaler.sv
// Game Boy line scaler: prefetches 2bpp framebuffer rows into a ping-pong line
// buffer and emits palette-mapped RGB, two clocks behind the VGA timing inputs.
module gb_line_scaler #(
  parameter logic [23:0] PAL0    = 24'hE0F8D0,
  parameter logic [23:0] PAL1    = 24'h88C070,
  parameter logic [23:0] PAL2    = 24'h346856,
  parameter logic [23:0] PAL3    = 24'h081820,
  parameter logic [23:0] BORDER  = 24'h000000,
  parameter bit          GRID_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        enable,
  input  logic        gb_en,
  input  logic        gb_grid,
  input  logic [7:0]  gb_x,
  input  logic [7:0]  gb_y,
  output logic        fb_req,
  output logic [12:0] fb_addr,
  input  logic        fb_valid,
  input  logic [7:0]  fb_rdata,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        de,
  output logic        hs_o,
  output logic        vs_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [5:0] LAST_WORD = 6'd39;

  function automatic logic [12:0] row_base(input logic [7:0] row);
    return {row, 5'd0} + {2'd0, row, 3'd0};
  endfunction

  function automatic logic [23:0] dim24(input logic [23:0] c);
    return {c[23:16] - {3'd0, c[23:19]}, c[15:8] - {3'd0, c[15:11]}, c[7:0] - {3'd0, c[7:3]}};
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       word_q, word_d;
  logic [7:0]       target_q, target_d;
  logic             pend_q, pend_d;
  logic             fb_req_q, fb_req_d;
  logic [12:0]      fb_addr_q, fb_addr_d;
  logic             front_q, front_d;
  logic [1:0]       valid_q, valid_d;
  logic [1:0][7:0]  tag_q, tag_d;

  logic             de1_q, de1_d, gben1_q, gben1_d, grid1_q, grid1_d;
  logic             hs1_q, hs1_d, vs1_q, vs1_d;
  logic [1:0]       pix1_q, pix1_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             de_q, de_d, hs_o_q, hs_o_d, vs_o_q, vs_o_d;

  logic [7:0]       bank0_mem [40];
  logic [7:0]       bank1_mem [40];
  logic             wr_en_s;

  logic             line_start_s, back_s, swap_s, new_front_s, new_back_s, nb_valid_s, start_s;
  logic [8:0]       target9_s;
  logic [7:0]       target_s;
  logic [5:0]       rd_idx_s;
  logic [7:0]       rd_byte_s;
  logic [1:0]       pick_s;
  logic [23:0]      pal_s;

  assign line_start_s = hs & ~hs1_q;

  // Line-start bank decision: swap first, then choose the row to prefetch.
  always_comb begin
    back_s      = ~front_q;
    swap_s      = valid_q[back_s] && (tag_q[back_s] == gb_y);
    new_front_s = swap_s ? back_s : front_q;
    new_back_s  = ~new_front_s;
    nb_valid_s  = swap_s ? 1'b0 : valid_q[new_back_s];
    if (valid_q[new_front_s] && (tag_q[new_front_s] == gb_y)) begin
      target9_s = {1'b0, gb_y} + 9'd1;
    end else begin
      target9_s = {1'b0, gb_y};
    end
    start_s  = (target9_s <= 9'd143) &&
               !(nb_valid_s && ({1'b0, tag_q[new_back_s]} == target9_s));
    target_s = target9_s[7:0];
  end

  // Fetch FSM next state; a request is always completed by fb_valid, even when abandoned.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    target_d  = target_q;
    pend_d    = pend_q;
    fb_req_d  = fb_req_q;
    fb_addr_d = fb_addr_q;
    front_d   = front_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    wr_en_s   = 1'b0;
    if (line_start_s) begin
      front_d = new_front_s;
      if (swap_s) begin
        valid_d[new_back_s] = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      front_d = front_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (line_start_s && start_s) begin
          state_d             = ST_FETCH;
          word_d              = 6'd0;
          target_d            = target_s;
          pend_d              = 1'b0;
          fb_req_d            = 1'b1;
          fb_addr_d           = row_base(target_s);
          valid_d[new_back_s] = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH, ST_DRAIN: begin
        if (line_start_s) begin
          target_d = target_s;
          pend_d   = start_s;
          state_d  = ST_DRAIN;
        end else begin
          state_d = state_q;
        end
        if (fb_valid && (state_d == ST_DRAIN)) begin
          // Stale word is dropped; restart on the freshly chosen row if any.
          word_d = 6'd0;
          if (pend_d) begin
            state_d   = ST_FETCH;
            fb_req_d  = 1'b1;
            fb_addr_d = row_base(target_d);
          end else begin
            state_d  = ST_IDLE;
            fb_req_d = 1'b0;
          end
        end else if (fb_valid) begin
          wr_en_s = 1'b1;
          if (word_q == LAST_WORD) begin
            state_d        = ST_IDLE;
            fb_req_d       = 1'b0;
            valid_d[back_s] = 1'b1;
            tag_d[back_s]   = target_q;
          end else begin
            word_d    = word_q + 6'd1;
            fb_addr_d = fb_addr_q + 13'd1;
          end
        end else begin
          wr_en_s = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        fb_req_d = 1'b0;
      end
    endcase
  end

  // Line buffer write port, always into the current back bank.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (back_s) begin
        bank1_mem[word_q] <= fb_rdata;
      end else begin
        bank0_mem[word_q] <= fb_rdata;
      end
    end
  end

  // Stage 1: front-bank pixel lookup and sideband capture.
  always_comb begin
    rd_idx_s  = (gb_x < 8'd160) ? gb_x[7:2] : 6'd0;
    rd_byte_s = front_q ? bank1_mem[rd_idx_s] : bank0_mem[rd_idx_s];
    case (gb_x[1:0])
      2'd0:    pick_s = rd_byte_s[1:0];
      2'd1:    pick_s = rd_byte_s[3:2];
      2'd2:    pick_s = rd_byte_s[5:4];
      2'd3:    pick_s = rd_byte_s[7:6];
      default: pick_s = 2'd0;
    endcase
    if (valid_q[front_q] && (gb_x < 8'd160)) begin
      pix1_d = pick_s;
    end else begin
      pix1_d = 2'd0;
    end
    de1_d   = enable;
    gben1_d = gb_en;
    grid1_d = gb_grid;
    hs1_d   = hs;
    vs1_d   = vs;
  end

  // Stage 2: palette, border and grid dimming.
  always_comb begin
    case (pix1_q)
      2'd0:    pal_s = PAL0;
      2'd1:    pal_s = PAL1;
      2'd2:    pal_s = PAL2;
      2'd3:    pal_s = PAL3;
      default: pal_s = PAL0;
    endcase
    if (!de1_q) begin
      rgb_d = 24'h000000;
    end else if (!gben1_q) begin
      rgb_d = BORDER;
    end else if (GRID_EN && grid1_q) begin
      rgb_d = dim24(pal_s);
    end else begin
      rgb_d = pal_s;
    end
    de_d   = de1_q;
    hs_o_d = hs1_q;
    vs_o_d = vs1_q;
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_q    <= 6'd0;
      target_q  <= 8'd0;
      pend_q    <= 1'b0;
      fb_req_q  <= 1'b0;
      fb_addr_q <= 13'd0;
      front_q   <= 1'b0;
      valid_q   <= 2'b00;
      tag_q     <= '0;
      de1_q     <= 1'b0;
      gben1_q   <= 1'b0;
      grid1_q   <= 1'b0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      pix1_q    <= 2'd0;
      rgb_q     <= 24'h000000;
      de_q      <= 1'b0;
      hs_o_q    <= 1'b1;
      vs_o_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      target_q  <= target_d;
      pend_q    <= pend_d;
      fb_req_q  <= fb_req_d;
      fb_addr_q <= fb_addr_d;
      front_q   <= front_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      de1_q     <= de1_d;
      gben1_q   <= gben1_d;
      grid1_q   <= grid1_d;
      hs1_q     <= hs1_d;
      vs1_q     <= vs1_d;
      pix1_q    <= pix1_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_o_q    <= hs_o_d;
      vs_o_q    <= vs_o_d;
    end
  end

  assign fb_req  = fb_req_q;
  assign fb_addr = fb_addr_q;
  assign r       = rgb_q[23:16];
  assign g       = rgb_q[15:8];
  assign b       = rgb_q[7:0];
  assign de      = de_q;
  assign hs_o    = hs_o_q;
  assign vs_o    = vs_o_q;

endmodule

// File: tb/tb_gb_line_scaler.sv
// Scoreboard bench for gb_line_scaler: a reduced VGA line generator, a latency
// model of the framebuffer, and queues of expected pixels and fetch addresses.
module tb_gb_line_scaler;

  localparam logic [23:0] P0 = 24'hE0F8D0;
  localparam logic [23:0] P1 = 24'h88C070;
  localparam logic [23:0] P2 = 24'h346856;
  localparam logic [23:0] P3 = 24'h081820;
  localparam logic [23:0] BRD = 24'h000000;
  localparam int LINE = 240;
  localparam int SYNC = 10;
  localparam int ACT0 = 20;

  logic        clk = 1'b0;
  logic        rst, hs, vs, enable, gb_en, gb_grid, fb_valid;
  logic [7:0]  gb_x, gb_y, fb_rdata;
  logic        fb_req, de, hs_o, vs_o;
  logic [12:0] fb_addr;
  logic [7:0]  r, g, b;
  logic        fb_req2, de2, hs_o2, vs_o2;
  logic [12:0] fb_addr2;
  logic [7:0]  r2, g2, b2;

  always #5 clk = ~clk;

  gb_line_scaler dut (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .enable(enable), .gb_en(gb_en),
    .gb_grid(gb_grid), .gb_x(gb_x), .gb_y(gb_y), .fb_req(fb_req), .fb_addr(fb_addr),
    .fb_valid(fb_valid), .fb_rdata(fb_rdata), .r(r), .g(g), .b(b), .de(de),
    .hs_o(hs_o), .vs_o(vs_o)
  );

  gb_line_scaler #(.GRID_EN(1'b0)) dut_ng (
    .clk(clk), .rst(rst), .hs(hs), .vs(vs), .enable(enable), .gb_en(gb_en),
    .gb_grid(gb_grid), .gb_x(gb_x), .gb_y(gb_y), .fb_req(fb_req2), .fb_addr(fb_addr2),
    .fb_valid(fb_valid), .fb_rdata(fb_rdata), .r(r2), .g(g2), .b(b2), .de(de2),
    .hs_o(hs_o2), .vs_o(vs_o2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    logic [26:0] e1;
    logic [26:0] e2;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] addr_q[$];

  int          lat = 2;
  logic [12:0] stall_addr = 13'h1FFF;
  int          stall_lat = 180;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [23:0] dim(input logic [23:0] c);
    logic [7:0] cr, cg, cb;
    cr = c[23:16]; cg = c[15:8]; cb = c[7:0];
    return {cr - cr / 8'd8, cg - cg / 8'd8, cb - cb / 8'd8};
  endfunction

  function automatic logic [23:0] pal(input int v);
    case (v)
      0: return P0;
      1: return P1;
      2: return P2;
      default: return P3;
    endcase
  endfunction

  function automatic logic [7:0] fb_word(input logic [12:0] a);
    int row, w;
    logic [7:0] d;
    row = int'(a) / 40;
    w = int'(a) % 40;
    for (int i = 0; i < 4; i++) d[2*i +: 2] = 2'((row + 4*w + i) & 3);
    return d;
  endfunction

  task automatic push_row(input int row, input int nwords);
    for (int w = 0; w < nwords; w++) addr_q.push_back(13'(row * 40 + w));
  endtask

  // Framebuffer model: one outstanding request, data after 'lat' clocks.
  initial begin
    logic [12:0] a;
    logic [12:0] e;
    int l;
    fb_valid = 1'b0;
    fb_rdata = 8'd0;
    @(negedge clk);
    forever begin
      if (fb_req === 1'b1 && rst === 1'b0) begin
        a = fb_addr;
        l = (a == stall_addr) ? stall_lat : lat;
        if (addr_q.size() == 0) begin
          n_chk++;
          $display("FAIL fb_unexpected: got request at %0d, expected none (t=%0t)", a, $time);
        end else begin
          e = addr_q.pop_front();
          check("fb_addr", 32'(a), 32'(e));
          check("fb_addr_nogrid", {19'd0, fb_req2, fb_addr2}, {19'd0, 1'b1, e});
        end
        repeat (l) @(negedge clk);
        if (fb_req === 1'b1 && rst === 1'b0) begin
          check("fb_addr_hold", 32'(fb_addr), 32'(a));
          fb_valid = 1'b1;
          fb_rdata = fb_word(a);
          @(negedge clk);
          fb_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // Pixel monitor: compares both instances whenever an expected output is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_chk++;
        $display("FAIL pix_missed: got no compare at cycle %0d, expected one (t=%0t)", e.cyc, $time);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        check("pix_grid", {5'd0, de, hs_o, vs_o, r, g, b}, {5'd0, e.e1});
        check("pix_nogrid", {5'd0, de2, hs_o2, vs_o2, r2, g2, b2}, {5'd0, e.e2});
      end
    end
  end

  // One VGA line; disp_row is the row expected in the front bank (-1 = none).
  task automatic drive_line(input int y, input bit vb, input int disp_row, input bit grid_on,
                            input int exp_upto, input int rst_at);
    exp_t       e;
    logic [23:0] c, c1, c2;
    for (int k = 0; k < LINE; k++) begin
      @(negedge clk);
      hs      = (k >= SYNC);
      vs      = !(vb && k < SYNC);
      enable  = (k >= ACT0 && k < ACT0 + 160);
      gb_en   = enable && !vb;
      gb_x    = enable ? 8'(k - ACT0) : 8'd0;
      gb_y    = 8'(y);
      gb_grid = grid_on && gb_en && (gb_x[2:0] == 3'd7);
      if (k < exp_upto) begin
        if (!enable) begin
          c1 = 24'h000000; c2 = 24'h000000;
        end else if (!gb_en) begin
          c1 = BRD; c2 = BRD;
        end else begin
          c = pal((disp_row < 0) ? 0 : ((disp_row + int'(gb_x)) & 3));
          c1 = gb_grid ? dim(c) : c;
          c2 = c;
        end
        e.cyc = cyc + 2;
        e.e1 = {enable, hs, vs, c1};
        e.e2 = {enable, hs, vs, c2};
        exp_q.push_back(e);
      end
      if (k == rst_at) begin
        check("req_before_rst", 32'(fb_req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req", 32'(fb_req), 32'd0);
        check("rst_mid_out", {6'd0, de, hs_o, vs_o, r, g, b}, {6'd0, 3'b011, 24'h000000});
        addr_q.delete();
      end
      if (k == rst_at + 4) rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b1; vs = 1'b1; enable = 1'b0; gb_en = 1'b0;
    gb_grid = 1'b0; gb_x = 8'd0; gb_y = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_rgb_de", {7'd0, de, r, g, b}, 32'd0);
    check("rst_syncs", {30'd0, hs_o, vs_o}, 32'd3);
    check("rst_fb", {18'd0, fb_req, fb_addr}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Vertical blank line prefetches row 0; each visible row prefetches the next.
    push_row(0, 40);
    drive_line(0, 1'b1, -1, 1'b1, LINE, -1);
    for (int y = 0; y < 12; y++) begin
      push_row(y + 1, 40);
      drive_line(y, 1'b0, y, 1'b1, LINE, -1);
    end

    // Row 13 word 30 stalls past the next line start, which jumps to row 20.
    stall_addr = 13'(13 * 40 + 30);
    push_row(13, 31);
    push_row(20, 40);
    drive_line(12, 1'b0, 12, 1'b1, LINE, -1);
    drive_line(20, 1'b0, 12, 1'b1, LINE, -1);

    // Row 20 now displayed; reset lands while row 21 is being fetched.
    push_row(21, 40);
    drive_line(20, 1'b0, 20, 1'b1, 50, 60);

    // After reset both banks are empty: PAL0 until the refetched row swaps in.
    push_row(21, 40);
    drive_line(21, 1'b0, -1, 1'b0, LINE, -1);
    push_row(22, 40);
    drive_line(21, 1'b0, 21, 1'b1, LINE, -1);

    repeat (10) @(negedge clk);
    check("pix_queue_empty", 32'(exp_q.size()), 32'd0);
    check("addr_queue_empty", 32'(addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
